// File: rtl/force_check_sequencer_pkg.sv
// Purpose : shared types and constants for the force/check sequencer.
//   seq_state_e   - sequencer FSM states
//   fail_code_e   - result codes reported on fail_code
//   MIN_PHASE_LEN - shortest duration of a timed phase, in cycles
package force_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_FORCE   = 3'd2,
        ST_CHK_F   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_CHK_R   = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_PASS     = 2'd0,
        FC_FORCED   = 2'd1,
        FC_RELEASED = 2'd2,
        FC_ABORT    = 2'd3
    } fail_code_e;

    localparam int unsigned MIN_PHASE_LEN = 1;

endpackage

// File: rtl/force_check_sequencer_if.sv
// Purpose : bundle of the sequencer's control, data and status signals.
//   master - requester side: drives start/abort/config and observed, reads status
//   slave  - sequencer side: reads requests, drives force and status outputs
interface force_check_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] pre_cycles;
    logic [CNT_W-1:0] hold_cycles;
    logic [CNT_W-1:0] settle_cycles;
    logic [WIDTH-1:0] force_val;
    logic [WIDTH-1:0] baseline_val;
    logic [WIDTH-1:0] observed;
    logic             force_en;
    logic [WIDTH-1:0] force_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;

    modport master (
        output start, abort, pre_cycles, hold_cycles, settle_cycles,
               force_val, baseline_val, observed,
        input  force_en, force_data, busy, done, pass, fail_code
    );

    modport slave (
        input  start, abort, pre_cycles, hold_cycles, settle_cycles,
               force_val, baseline_val, observed,
        output force_en, force_data, busy, done, pass, fail_code
    );
endinterface

// File: rtl/force_check_sequencer_phase_counter.sv
// Purpose : down-counter timing one phase of the sequence. It is loaded
//           with (phase length - 1) on phase entry; o_expired flags the last
//           cycle of the phase.
// Ports   : clk, rst_n       - clock, async active-low reset
//           i_clear          - return count to zero
//           i_load/i_load_val- load a new remaining-cycle count
//           i_dec            - count down by one (saturates at zero)
//           o_expired        - remaining count is zero
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/force_check_sequencer.sv
// Purpose : runs one force / check / release / check sequence against a
//           downstream forceable register and reports the result.
// Ports   : clk, rst_n - clock, async active-low reset
//           bus (slave)- start/abort requests, phase lengths, force and
//                        baseline values, observed data in; force_en,
//                        force_data, busy, done, pass, fail_code out.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_PRE     | settle time before forcing, max(pre_cycles,1) cycles
// ST_FORCE   | force applied, max(hold_cycles,1) cycles
// ST_CHK_F   | force still applied, observed compared to force value
// ST_RELEASE | force removed, max(settle_cycles,1) cycles
// ST_CHK_R   | observed compared to baseline value
// ST_DONE    | one-cycle done pulse, result published
module force_check_sequencer
    import force_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    force_check_sequencer_if.slave bus
);
    seq_state_e       r_state;
    seq_state_e       w_next_state;
    fail_code_e       r_code;
    fail_code_e       w_code_next;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_settle;
    logic [WIDTH-1:0] r_force_val;
    logic [WIDTH-1:0] r_baseline;
    logic             r_force_en;
    logic [WIDTH-1:0] r_force_data;
    logic             r_pass;
    logic [1:0]       r_fail_code;

    logic             w_busy;
    logic             w_capture;
    logic             w_cnt_clear;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_expired;
    logic             w_force_next;

    // Counter holds remaining cycles after the current one, so a phase of
    // length L is loaded with L-1; lengths below the minimum are stretched.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] n);
        if (n < CNT_W'(MIN_PHASE_LEN)) return CNT_W'(MIN_PHASE_LEN - 1);
        else                           return n - CNT_W'(1);
    endfunction

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_cnt_clear),
        .i_load    (w_cnt_load),
        .i_load_val(w_cnt_load_val),
        .i_dec     (w_cnt_dec),
        .o_expired (w_expired)
    );

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

    always_comb begin
        w_next_state   = r_state;
        w_code_next    = r_code;
        w_capture      = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        if (w_busy && bus.abort) begin
            w_next_state = ST_DONE;
            w_code_next  = FC_ABORT;
            w_cnt_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // abort on the acceptance cycle wins: report abort
                        // without ever starting the sequence
                        if (bus.abort) begin
                            w_next_state = ST_DONE;
                            w_code_next  = FC_ABORT;
                        end else begin
                            w_next_state   = ST_PRE;
                            w_code_next    = FC_PASS;
                            w_capture      = 1'b1;
                            w_cnt_load     = 1'b1;
                            w_cnt_load_val = phase_load(bus.pre_cycles);
                        end
                    end
                end
                ST_PRE: begin
                    if (w_expired) begin
                        w_next_state   = ST_FORCE;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = phase_load(r_hold);
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_FORCE: begin
                    if (w_expired) w_next_state = ST_CHK_F;
                    else           w_cnt_dec    = 1'b1;
                end
                ST_CHK_F: begin
                    if (bus.observed != r_force_val) w_code_next = FC_FORCED;
                    w_next_state   = ST_RELEASE;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = phase_load(r_settle);
                end
                ST_RELEASE: begin
                    if (w_expired) w_next_state = ST_CHK_R;
                    else           w_cnt_dec    = 1'b1;
                end
                ST_CHK_R: begin
                    // first recorded failure is the one reported
                    if ((bus.observed != r_baseline) && (r_code == FC_PASS))
                        w_code_next = FC_RELEASED;
                    w_next_state = ST_DONE;
                end
                ST_DONE: begin
                    w_next_state = ST_IDLE;
                    w_cnt_clear  = 1'b1;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    assign w_force_next = (w_next_state == ST_FORCE) || (w_next_state == ST_CHK_F);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_code       <= FC_PASS;
            r_hold       <= '0;
            r_settle     <= '0;
            r_force_val  <= '0;
            r_baseline   <= '0;
            r_force_en   <= 1'b0;
            r_force_data <= '0;
            r_pass       <= 1'b0;
            r_fail_code  <= 2'd0;
        end else begin
            r_state    <= w_next_state;
            r_code     <= w_code_next;
            r_force_en <= w_force_next;
            // FORCE is never entered on the capture edge, so the captured
            // value is already in r_force_val whenever force is requested
            r_force_data <= w_force_next ? r_force_val : '0;
            if (w_capture) begin
                r_hold      <= bus.hold_cycles;
                r_settle    <= bus.settle_cycles;
                r_force_val <= bus.force_val;
                r_baseline  <= bus.baseline_val;
            end
            if ((w_next_state == ST_DONE) && (r_state != ST_DONE)) begin
                r_fail_code <= w_code_next;
                r_pass      <= (w_code_next == FC_PASS);
            end
        end
    end

    assign bus.force_en   = r_force_en;
    assign bus.force_data = r_force_data;
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.pass       = r_pass;
    assign bus.fail_code  = r_fail_code;
endmodule

// File: doc/force_check_sequencer.md
FORCE_CHECK_SEQUENCER -- requirements
Module: force_check_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, width of forced/observed data.
REQ-002 Parameter CNT_W, default 8, width of phase-length fields.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-004 start  input  1  one-cycle request to run one force/check/release/check sequence.
REQ-005 abort  input  1  terminates a running sequence.
REQ-006 pre_cycles, hold_cycles, settle_cycles  input  CNT_W each  phase lengths in cycles.
REQ-007 force_val  input  WIDTH  value to force; baseline_val  input  WIDTH  expected value after release.
REQ-008 observed  input  WIDTH  output of the downstream forceable register.
REQ-009 force_en  output  1  force request to the downstream register; force_data  output  WIDTH  forced value.
REQ-010 busy  output  1  sequence in progress; done  output  1  one-cycle completion pulse.
REQ-011 pass  output  1  result of last sequence; fail_code  output  2  0 pass, 1 forced mismatch, 2 released mismatch, 3 aborted.

Function
REQ-012 FSM states: IDLE, PRE, FORCE, CHK_F, RELEASE, CHK_R, DONE.
REQ-013 IDLE->PRE on start; start SHALL be ignored outside IDLE.
REQ-014 Phase lengths, operands and force_val SHALL be captured on the accepted start cycle; later input changes SHALL NOT affect the running sequence.
REQ-015 PRE, FORCE and RELEASE SHALL each last max(N,1) cycles, N being the captured length; a length of 0 behaves as 1.
REQ-016 force_en SHALL be registered and high exactly during FORCE and CHK_F; force_data SHALL equal captured force_val whenever force_en is high, else 0.
REQ-017 CHK_F (1 cycle): observed SHALL be compared to captured force_val; mismatch records code 1; the sequence continues regardless.
REQ-018 CHK_R (1 cycle): observed SHALL be compared to captured baseline_val; mismatch records code 2 only if no earlier code is recorded.
REQ-019 DONE (1 cycle): done=1, busy=0 thereafter, pass=(code==0), fail_code updated; DONE->IDLE.
REQ-020 busy SHALL be high in every state except IDLE and DONE.
REQ-021 abort in any busy state SHALL drop force_en on the next edge, go to DONE with fail_code=3 and pass=0; abort SHALL have priority over every phase transition, including on the start-acceptance cycle (abort wins; sequence not started).
REQ-022 pass and fail_code SHALL hold their values until the next DONE.
REQ-023 Minimum sequence (all lengths 0): start at edge t, done high in cycle t+6.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, force_en=0, force_data=0, busy=0, done=0, pass=0, fail_code=0, counters=0.
REQ-025 Reset mid-sequence SHALL release force without a done pulse; deassertion SHALL be treated as synchronous to clk by the reset synchroniser upstream.

Structure
REQ-026 Package force_seq_pkg SHALL hold the state enum, the fail-code enum (FC_PASS, FC_FORCED, FC_RELEASED, FC_ABORT) and the minimum phase length constant.
REQ-027 One sub-module, phase_counter (load value, decrement, expire flag, clear), SHALL be instantiated once and reused for PRE, FORCE and RELEASE.
REQ-028 The total RTL SHALL be synthesizable and simulate under Verilator with --timing off.

Verification
REQ-029 pre=3, hold=4, settle=3, force_val=0x5A, observed follows force_en (0x5A forced, 0x00 baseline), baseline_val=0x00 -> force_en high for 5 cycles, done at t+13, pass=1, fail_code=0.
REQ-030 Same run with observed stuck at 0x00 -> done at t+13, pass=0, fail_code=1.
REQ-031 Observed correct while forced but 0xFF after release -> fail_code=2, pass=0.
REQ-032 abort asserted in third FORCE cycle -> force_en low next cycle, done next cycle, fail_code=3; second start pulse during busy ignored.
REQ-033 All lengths 0 -> done at t+6; start and abort on same cycle -> fail_code=3, force_en never high.
REQ-034 rst_n low during FORCE -> force_en, busy, fail_code zero immediately; no done pulse; fresh start after reset completes normally.
